// File: rtl/mcu_port_bridge.sv
// mcu_port_bridge: buffered byte bridge between the MCU port command channel
// and the core's serial device. Two show-ahead FIFOs (core->MCU, MCU->core),
// byte-availability counts, registered port status word and a drop counter.
// Optional feature macro: MCU_PORT_DROP_CNT_EN (drop counter built when defined;
// otherwise drop_cnt is tied to zero and overflow bytes are still discarded).

module mcu_port_bridge_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [7:0]            wdata_i,
  output logic [7:0]            rdata_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  drop_o
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LAST_C  = (DEPTH_LOG2 + 1)'(DEPTH - 1);
  localparam logic [DEPTH_LOG2:0] ONE_C   = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_e;

  state_e              state_q, state_d;
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic [7:0]          hold_q;
  logic [7:0]          mem_q [DEPTH];
  logic                pop_ok, push_ok;
  logic                unused_ptr_msb;

  // A pop on a full FIFO frees the slot first, so a same-cycle push is accepted.
  assign pop_ok  = pop_i && (state_q != S_EMPTY);
  assign push_ok = push_i && ((state_q != S_FULL) || pop_ok);
  assign drop_o  = push_i && !push_ok;

  // Pointers stay below DEPTH, so their top bit never addresses memory.
  assign unused_ptr_msb = wr_ptr_q[DEPTH_LOG2] ^ rd_ptr_q[DEPTH_LOG2];

  // Show-ahead head; once empty, keep presenting the last byte popped.
  assign rdata_o = (state_q == S_EMPTY) ? hold_q : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign count_o = count_q;
  assign full_o  = (state_q == S_FULL);
  assign empty_o = (state_q == S_EMPTY);

  // Next-state for pointers, occupancy and EMPTY/PARTIAL/FULL state; flush wins.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + ONE_C;
      if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + ONE_C;
      if (push_ok && !pop_ok)      count_d = count_q + ONE_C;
      else if (pop_ok && !push_ok) count_d = count_q - ONE_C;
    end
    if (count_d == '0)          state_d = S_EMPTY;
    else if (count_d == DEPTH_C) state_d = S_FULL;
    else                         state_d = S_PARTIAL;
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_EMPTY;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      if (pop_ok && !flush_i) hold_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end
  end

  // Storage array; contents only become visible through a valid count.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
  end
endmodule

module mcu_port_bridge #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  output logic [7:0]  port_out_available,
  input  logic        port_out_strobe,
  output logic [7:0]  port_out_data,
  output logic [7:0]  port_in_available,
  input  logic        port_in_strobe,
  input  logic [7:0]  port_in_data,
  output logic [31:0] port_status,
  input  logic [23:0] cfg_bitrate,
  input  logic [7:0]  cfg_frame,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  drop_cnt
);
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

  logic [DEPTH_LOG2:0] out_count, in_count;
  logic                out_full, out_empty, in_full, in_empty;
  logic                out_drop, in_drop;
  logic                unused_flags;
  logic [31:0]         status_q;

  mcu_port_bridge_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_out_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (flush),
    .push_i  (tx_valid),
    .pop_i   (port_out_strobe),
    .wdata_i (tx_data),
    .rdata_o (port_out_data),
    .count_o (out_count),
    .full_o  (out_full),
    .empty_o (out_empty),
    .drop_o  (out_drop)
  );

  mcu_port_bridge_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_in_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (flush),
    .push_i  (port_in_strobe),
    .pop_i   (rx_ready),
    .wdata_i (port_in_data),
    .rdata_o (rx_data),
    .count_o (in_count),
    .full_o  (in_full),
    .empty_o (in_empty),
    .drop_o  (in_drop)
  );

  assign tx_ready           = !out_full;
  assign rx_valid           = !in_empty;
  assign port_out_available = 8'(out_count);
  assign port_in_available  = 8'(DEPTH_C - in_count);
  assign port_status        = status_q;
  assign unused_flags       = out_empty ^ in_full ^ out_drop;

  // Status word: byte-swapped bitrate followed by the frame format.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) status_q <= '0;
    else          status_q <= {cfg_bitrate[7:0], cfg_bitrate[15:8], cfg_bitrate[23:16], cfg_frame};
  end

`ifdef MCU_PORT_DROP_CNT_EN
  logic [7:0] drop_q;

  // Saturating count of MCU bytes discarded by the full MCU->core FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        drop_q <= '0;
    else if (flush)                      drop_q <= '0;
    else if (in_drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end

  assign drop_cnt = drop_q;
`else
  logic unused_drop;
  assign unused_drop = in_drop;
  assign drop_cnt    = '0;
`endif
endmodule

// File: tb/tb_mcu_port_bridge.sv
// Directed self-checking bench for mcu_port_bridge (DEPTH_LOG2 = 4).
module tb_mcu_port_bridge;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  port_out_available;
  logic        port_out_strobe = 1'b0;
  logic [7:0]  port_out_data;
  logic [7:0]  port_in_available;
  logic        port_in_strobe = 1'b0;
  logic [7:0]  port_in_data = '0;
  logic [31:0] port_status;
  logic [23:0] cfg_bitrate = '0;
  logic [7:0]  cfg_frame = '0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready = 1'b0;
  logic [7:0]  drop_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  exp_drop;

  always #5 clk = ~clk;

  mcu_port_bridge #(.DEPTH_LOG2(4)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .flush              (flush),
    .port_out_available (port_out_available),
    .port_out_strobe    (port_out_strobe),
    .port_out_data      (port_out_data),
    .port_in_available  (port_in_available),
    .port_in_strobe     (port_in_strobe),
    .port_in_data       (port_in_data),
    .port_status        (port_status),
    .cfg_bitrate        (cfg_bitrate),
    .cfg_frame          (cfg_frame),
    .tx_valid           (tx_valid),
    .tx_data            (tx_data),
    .tx_ready           (tx_ready),
    .rx_valid           (rx_valid),
    .rx_data            (rx_data),
    .rx_ready           (rx_ready),
    .drop_cnt           (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef MCU_PORT_DROP_CNT_EN
    exp_drop = 8'd2;
`else
    exp_drop = 8'd0;
`endif
    #12;
    check("rst_out_avail", {24'd0, port_out_available}, 32'd0);
    check("rst_in_avail",  {24'd0, port_in_available}, 32'd16);
    reset_n = 1'b1;
    tick();
    check("rst_tx_ready",  {31'd0, tx_ready}, 32'd1);
    check("rst_rx_valid",  {31'd0, rx_valid}, 32'd0);
    check("rst_drop",      {24'd0, drop_cnt}, 32'd0);
    check("rst_out_data",  {24'd0, port_out_data}, 32'd0);
    check("rst_rx_data",   {24'd0, rx_data}, 32'd0);
    check("rst_in_avail2", {24'd0, port_in_available}, 32'd16);

    // Pop on empty is ignored.
    port_out_strobe = 1'b1;
    tick();
    port_out_strobe = 1'b0;
    check("empty_pop", {24'd0, port_out_available}, 32'd0);

    // Core->MCU ordering and no-bubble pops.
    tx_valid = 1'b1;
    tx_data = 8'h11; tick();
    check("push1_avail", {24'd0, port_out_available}, 32'd1);
    check("push1_head",  {24'd0, port_out_data}, 32'h11);
    tx_data = 8'h22; tick();
    tx_data = 8'h33; tick();
    tx_valid = 1'b0;
    check("c2m_avail3", {24'd0, port_out_available}, 32'd3);
    check("c2m_head0",  {24'd0, port_out_data}, 32'h11);
    port_out_strobe = 1'b1;
    tick();
    check("c2m_avail2", {24'd0, port_out_available}, 32'd2);
    check("c2m_head1",  {24'd0, port_out_data}, 32'h22);
    tick();
    check("c2m_avail1", {24'd0, port_out_available}, 32'd1);
    check("c2m_head2",  {24'd0, port_out_data}, 32'h33);
    tick();
    port_out_strobe = 1'b0;
    check("c2m_avail0", {24'd0, port_out_available}, 32'd0);
    check("c2m_tx_rdy", {31'd0, tx_ready}, 32'd1);

    // MCU->core overflow: 18 writes into a 16-deep FIFO.
    port_in_strobe = 1'b1;
    for (int i = 0; i < 18; i++) begin
      port_in_data = 8'hA0 + 8'(i);
      tick();
    end
    port_in_strobe = 1'b0;
    check("ovf_in_avail", {24'd0, port_in_available}, 32'd0);
    check("ovf_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("ovf_drop",     {24'd0, drop_cnt}, {24'd0, exp_drop});
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), {24'd0, rx_data}, 32'hA0 + 32'(i));
      tick();
    end
    rx_ready = 1'b0;
    check("drain_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("drain_in_avail", {24'd0, port_in_available}, 32'd16);
    check("drain_drop",     {24'd0, drop_cnt}, {24'd0, exp_drop});

    // Simultaneous push and pop on a full core->MCU FIFO.
    tx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_data = 8'h40 + 8'(i);
      tick();
    end
    check("full_avail", {24'd0, port_out_available}, 32'd16);
    check("full_tx_rdy", {31'd0, tx_ready}, 32'd0);
    tx_data = 8'hEE;
    port_out_strobe = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("sim_avail",  {24'd0, port_out_available}, 32'd16);
    check("sim_tx_rdy", {31'd0, tx_ready}, 32'd0);
    check("sim_head",   {24'd0, port_out_data}, 32'h41);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("sim_drain_%0d", i), {24'd0, port_out_data}, 32'h40 + 32'(i));
      tick();
    end
    check("sim_new_byte", {24'd0, port_out_data}, 32'hEE);
    check("sim_last_avail", {24'd0, port_out_available}, 32'd1);
    tick();
    port_out_strobe = 1'b0;
    check("sim_empty", {24'd0, port_out_available}, 32'd0);

    // Status word.
    cfg_bitrate = 24'h01C200;
    cfg_frame = 8'h84;
    tick();
    check("status", port_status, 32'h00C20184);
    cfg_bitrate = 24'h123456;
    cfg_frame = 8'h7E;
    tick();
    check("status2", port_status, 32'h5634127E);

    // Flush with data in both FIFOs and a pending drop; flush beats a push.
    port_in_strobe = 1'b1;
    for (int i = 0; i < 17; i++) begin
      port_in_data = 8'h60 + 8'(i);
      tick();
    end
    port_in_strobe = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'h55; tick();
    tx_data = 8'h66; tick();
    check("pre_flush_out", {24'd0, port_out_available}, 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tx_valid = 1'b0;
    check("flush_out_avail", {24'd0, port_out_available}, 32'd0);
    check("flush_in_avail",  {24'd0, port_in_available}, 32'd16);
    check("flush_drop",      {24'd0, drop_cnt}, 32'd0);
    check("flush_rx_valid",  {31'd0, rx_valid}, 32'd0);

    // Asynchronous reset mid-transfer.
    tx_valid = 1'b1;
    tx_data = 8'h77; tick();
    tx_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_rst_out", {24'd0, port_out_available}, 32'd0);
    check("async_rst_status", port_status, 32'd0);
    #10;
    reset_n = 1'b1;
    tick();
    check("post_rst_out", {24'd0, port_out_available}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mcu_port_bridge.md
# mcu_port_bridge

Buffered bridge between the MCU port command channel in system control and the core's serial device (RS232/UP9600 UART). Two independent show-ahead FIFOs carry bytes core→MCU and MCU→core. The bridge derives the byte-availability counts, the port status word and the FIFO strobes that the port sub-commands rely on. It sits between the system controller's port interface and the UART glue in the core top level.

## Interface
Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 per direction; legal range 2..7.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of both FIFOs and the drop counter.
- port_out_available  out  8  bytes held in the core→MCU FIFO.
- port_out_strobe  in  1  MCU read acknowledge; pops the core→MCU FIFO.
- port_out_data  out  8  head of the core→MCU FIFO (show-ahead).
- port_in_available  out  8  free entries in the MCU→core FIFO.
- port_in_strobe  in  1  MCU write; pushes port_in_data.
- port_in_data  in  8  byte from the MCU.
- port_status  out  32  {bitrate[7:0], bitrate[15:8], bitrate[23:16], frame[7:0]}.
- cfg_bitrate  in  24  current UART bitrate in bit/s.
- cfg_frame  in  8  {databits[3:0], parity[1:0], stopbits[1:0]}.
- tx_valid  in  1  core offers a byte toward the MCU.
- tx_data  in  8  byte toward the MCU.
- tx_ready  out  1  core→MCU FIFO not full.
- rx_valid  out  1  MCU→core FIFO not empty.
- rx_data  out  8  head of the MCU→core FIFO (show-ahead).
- rx_ready  in  1  core accepts rx_data.
- drop_cnt  out  8  saturating count of bytes lost to full FIFOs.

## Operation
- Each FIFO has a write pointer, a read pointer and a count, each DEPTH_LOG2+1 bits wide. Pointers wrap modulo 2^DEPTH_LOG2.
- **Core→MCU FIFO**
  - Push on tx_valid & tx_ready.
  - Pop on port_out_strobe when count≠0. A pop on an empty FIFO is ignored.
- **MCU→core FIFO**
  - Push on port_in_strobe. The MCU does not flow-control, so when the FIFO is full the byte is discarded and drop_cnt increments.
  - Pop on rx_valid & rx_ready.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged. This also holds when the FIFO is full, because the pop frees the slot first and the push is not dropped.
- port_out_available = count of the core→MCU FIFO. port_in_available = 2^DEPTH_LOG2 − count of the MCU→core FIFO. Both are zero-extended to 8 bits.
- drop_cnt saturates at 0xFF. It is cleared only by reset or flush.
- flush takes priority over any push or pop in the same cycle.
- port_status is a registered copy of the cfg inputs, updated every cycle.
- **States per FIFO:** EMPTY (count=0), PARTIAL, FULL (count=2^DEPTH_LOG2).
  - A single push moves EMPTY→PARTIAL or PARTIAL→FULL (the latter when count reaches the depth).
  - A single pop moves FULL→PARTIAL or PARTIAL→EMPTY.
  - flush moves any state to EMPTY.

## Timing
- **Reset values:**
  - port_out_available 0, port_out_data 0x00, port_in_available 2^DEPTH_LOG2, port_status 0.
  - tx_ready 1, rx_valid 0, rx_data 0x00, drop_cnt 0.
- **Push latency:** a byte pushed at edge N is visible at the FIFO head, and reflected in the counts, after edge N (one cycle).
- **Pop latency:** after the popping edge, port_out_data and rx_data show the next entry within the same cycle. There is no bubble.
  - This is required because the MCU consumes one byte per transfer and strobes the next pop while capturing port_out_data.
- port_out_data and rx_data hold their last value when the FIFO is empty. They are don't-care to consumers, but must not be X.
- **port_status:** one-cycle latency from the cfg inputs.
- **Reset during a transfer:** asserting reset_n low clears all state immediately. In-flight bytes are lost and no strobe is remembered.

## Configuration
- MCU_PORT_DROP_CNT_EN:
  - Defined: the drop counter is implemented as specified above.
  - Undefined: no counter logic is built and drop_cnt is tied to 0x00. Overflow bytes are still discarded.

## Test plan
- **Reset:** with DEPTH_LOG2=4, release reset_n -> port_in_available=16, port_out_available=0, tx_ready=1, rx_valid=0, drop_cnt=0.
- **Core→MCU order:** push 0x11,0x22,0x33 via tx, then pulse port_out_strobe once per cycle -> port_out_available goes 3,2,1,0 and port_out_data reads 0x11,0x22,0x33 with no bubble.
- **MCU→core overflow:** 18 port_in_strobe pulses with rx_ready=0 -> port_in_available reaches 0, rx_valid=1, drop_cnt=2. Draining yields the first 16 bytes in order.
- **Simultaneous full push/pop:** core→MCU FIFO at 16, tx_valid and port_out_strobe asserted together -> count stays 16, the new byte is stored, and tx_ready stays 0.
- **Status/flush:** cfg_bitrate=0x01C200 and cfg_frame=0x84 -> port_status=0x00C20184 one cycle later. Then flush with data in both FIFOs -> both counts are 0 next cycle and drop_cnt=0.
- **Macro off:** build without MCU_PORT_DROP_CNT_EN and repeat the overflow scenario -> drop_cnt stays 0x00 and the data order is unchanged.
